// File: rtl/dac_multich_buffered.sv
// Behavioural N-channel double-buffered DAC: input registers, DAC registers loaded on ldac/write-update,
// a modelled settling delay before the real-valued outputs move, and a synchronous clear.
module dac_multich_buffered #(
    parameter int NCH        = 4,
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 3,
    parameter int CLR_CODE   = 0,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [CHW-1:0]         wr_ch,
    input  logic [WIDTH-1:0]       wr_code,
    input  logic                   wr_update,
    input  logic                   ldac,
    input  logic                   clr,
    input  real                    vref,
    output logic [NCH*WIDTH-1:0]   dac_code,
    output real                    vout [NCH],
    output logic                   busy,
    output logic                   wr_err
);

    localparam logic [0:0]       S_IDLE     = 1'b0;
    localparam logic [0:0]       S_SETTLE   = 1'b1;
    localparam int               CW         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0]    CNT_RELOAD = CW'(SETTLE_CYC - 1);
    localparam logic [WIDTH-1:0] CLR_VAL    = WIDTH'(CLR_CODE);
    localparam real              FULL       = (2.0 ** WIDTH) - 1.0;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] inp_q [NCH];
    logic [WIDTH-1:0] inp_d [NCH];
    logic [WIDTH-1:0] dac_q [NCH];
    logic [WIDTH-1:0] dac_d [NCH];
    real              vout_q [NCH];

    logic acc;
    logic ch_ok;
    logic upd;
    logic vout_ld;

    assign wr_ready = !((state_q == S_SETTLE) && pend_q);
    assign busy     = busy_q;
    assign wr_err   = err_q;

    always_comb begin
        acc   = wr_valid && wr_ready;
        ch_ok = int'(wr_ch) < NCH;
        upd   = ldac || (acc && wr_update);
        err_d = acc && !ch_ok;

        // Same-edge write is folded into inp_d so a DAC load on this edge sees it.
        for (int unsigned i = 0; i < NCH; i++) begin
            inp_d[i] = inp_q[i];
            if (acc && ch_ok && (wr_ch == CHW'(i)))
                inp_d[i] = wr_code;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        vout_ld = 1'b0;
        for (int unsigned i = 0; i < NCH; i++)
            dac_d[i] = dac_q[i];

        case (state_q)
            S_IDLE: begin
                if (upd) begin
                    for (int unsigned i = 0; i < NCH; i++)
                        dac_d[i] = inp_d[i];
                    cnt_d   = CNT_RELOAD;
                    state_d = S_SETTLE;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    vout_ld = 1'b1;
                    if (pend_q || upd) begin
                        // Back-to-back settle: outputs take the old DAC value, registers reload.
                        pend_d = 1'b0;
                        for (int unsigned i = 0; i < NCH; i++)
                            dac_d[i] = inp_d[i];
                        cnt_d  = CNT_RELOAD;
                        busy_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (upd)
                        pend_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                inp_q[i]  <= '0;
                dac_q[i]  <= '0;
                vout_q[i] <= 0.0;
            end
        end else if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                inp_q[i]  <= CLR_VAL;
                dac_q[i]  <= CLR_VAL;
                vout_q[i] <= vref * real'(CLR_VAL) / FULL;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                inp_q[i] <= inp_d[i];
                dac_q[i] <= dac_d[i];
                if (vout_ld)
                    vout_q[i] <= vref * real'(dac_q[i]) / FULL;
            end
        end
    end

    always_comb begin
        dac_code = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            dac_code[i*WIDTH +: WIDTH] = dac_q[i];
            vout[i]                    = vout_q[i];
        end
    end

endmodule

// File: tb/tb_dac_multich_buffered.sv
// Scoreboarded bench for dac_multich_buffered: a 4-channel instance (clear code 128) and a
// 3-channel instance for out-of-range channel writes.
module tb_dac_multich_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_valid, wr_ready, wr_update, ldac, clr, busy, wr_err;
    logic [1:0]  wr_ch;
    logic [7:0]  wr_code;
    logic [31:0] dac_code;
    real         vref;
    real         vout [4];

    logic        b_wr_valid, b_wr_ready, b_wr_update, b_ldac, b_clr, b_busy, b_wr_err;
    logic [1:0]  b_wr_ch;
    logic [7:0]  b_wr_code;
    logic [23:0] b_dac_code;
    real         b_vref;
    real         b_vout [3];

    dac_multich_buffered #(.NCH(4), .WIDTH(8), .SETTLE_CYC(3), .CLR_CODE(128)) u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
        .wr_code(wr_code), .wr_update(wr_update), .ldac(ldac), .clr(clr), .vref(vref),
        .dac_code(dac_code), .vout(vout), .busy(busy), .wr_err(wr_err)
    );

    dac_multich_buffered #(.NCH(3), .WIDTH(8), .SETTLE_CYC(3), .CLR_CODE(0)) u_dut3 (
        .clk(clk), .rst(rst), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_ch(b_wr_ch),
        .wr_code(b_wr_code), .wr_update(b_wr_update), .ldac(b_ldac), .clr(b_clr), .vref(b_vref),
        .dac_code(b_dac_code), .vout(b_vout), .busy(b_busy), .wr_err(b_wr_err)
    );

    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    int  due_q [$];
    real exp_q [$];
    real cur [4];

    task automatic check_val(input string tag, input real got, input real exp);
        checks++;
        if ((got - exp > 1.0e-6) || (exp - got > 1.0e-6)) begin
            errors++;
            $display("FAIL %s: got %f expected %f", tag, got, exp);
        end
    endtask

    task automatic expect_vout(input int due, input real v0, input real v1, input real v2, input real v3);
        due_q.push_back(due);
        exp_q.push_back(v0);
        exp_q.push_back(v1);
        exp_q.push_back(v2);
        exp_q.push_back(v3);
    endtask

    // One clock; expected vout moves only at the scheduled edge, otherwise it must hold.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            for (int i = 0; i < 4; i++) cur[i] = exp_q.pop_front();
        end
        for (int i = 0; i < 4; i++)
            check_val($sformatf("vout%0d@%0d", i, cyc), vout[i], cur[i]);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] code, input logic upd);
        wr_valid  = 1'b1;
        wr_ch     = ch;
        wr_code   = code;
        wr_update = upd;
    endtask

    task automatic wr_off();
        wr_valid  = 1'b0;
        wr_update = 1'b0;
    endtask

    int l0;

    initial begin
        for (int i = 0; i < 4; i++) cur[i] = 0.0;
        rst = 1'b1; wr_valid = 1'b0; wr_update = 1'b0; ldac = 1'b0; clr = 1'b0;
        wr_ch = '0; wr_code = '0; vref = 2.55;
        b_wr_valid = 1'b0; b_wr_update = 1'b0; b_ldac = 1'b0; b_clr = 1'b0;
        b_wr_ch = '0; b_wr_code = '0; b_vref = 2.55;
        step(); step();
        rst = 1'b0;

        // reset state
        check_val("rst_busy", busy, 0.0);
        check_val("rst_ready", wr_ready, 1.0);
        check_val("rst_code", real'(dac_code), 0.0);
        check_val("rst_b_busy", b_busy, 0.0);

        // write + update: vout[1] = 2.55*100/255 three edges after accept
        wr(2'd1, 8'd100, 1'b1);
        expect_vout(cyc + 4, 0.0, 1.0, 0.0, 0.0);
        step();
        wr_off();
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("t2_busy%0d", k), busy, 1.0);
            step();
        end
        check_val("t2_busy_end", busy, 0.0);
        check_val("t2_dac1", real'(dac_code[15:8]), 100.0);

        // staged load, then ldac
        wr(2'd0, 8'd255, 1'b0);
        step();
        wr(2'd2, 8'd51, 1'b0);
        step();
        wr_off();
        step(); step();
        check_val("t3_busy_idle", busy, 0.0);
        ldac = 1'b1;
        expect_vout(cyc + 4, 2.55, 1.0, 0.51, 0.0);
        step();
        ldac = 1'b0;
        step(); step(); step();
        check_val("t3_busy_end", busy, 0.0);

        // update during settle: second result six edges after the first ldac
        ldac = 1'b1;
        l0 = cyc + 1;
        expect_vout(l0 + 3, 2.55, 1.0, 0.51, 0.0);
        step();
        ldac = 1'b0;
        step();
        wr(2'd3, 8'd200, 1'b1);
        expect_vout(l0 + 6, 2.55, 1.0, 0.51, 2.0);
        step();
        wr_off();
        check_val("t4_ready_pend", wr_ready, 0.0);
        check_val("t4_busy_pend", busy, 1.0);
        step();
        check_val("t4_ready_after", wr_ready, 1.0);
        check_val("t4_busy_restart", busy, 1.0);
        step(); step(); step();
        check_val("t4_busy_end", busy, 0.0);
        check_val("t4_dac3", real'(dac_code[31:24]), 200.0);

        // clear mid-settle with a pending update and a same-cycle ldac
        wr(2'd0, 8'd10, 1'b1);
        step();
        wr_off();
        ldac = 1'b1;
        step();
        check_val("t5_ready_pend", wr_ready, 0.0);
        clr = 1'b1;
        expect_vout(cyc + 1, 1.28, 1.28, 1.28, 1.28);
        step();
        clr = 1'b0;
        ldac = 1'b0;
        check_val("t5_busy", busy, 0.0);
        check_val("t5_ready", wr_ready, 1.0);
        check_val("t5_code", real'(dac_code), real'(32'h8080_8080));
        for (int k = 0; k < 6; k++) step();
        check_val("t5_busy_end", busy, 0.0);

        // bad channel on the 3-channel instance
        b_wr_valid = 1'b1; b_wr_ch = 2'd1; b_wr_code = 8'd60;
        step();
        check_val("t6_err_good", b_wr_err, 0.0);
        b_wr_ch = 2'd3; b_wr_code = 8'd99;
        step();
        b_wr_valid = 1'b0;
        check_val("t6_err_pulse", b_wr_err, 1.0);
        check_val("t6_code_hold", real'(b_dac_code), 0.0);
        step();
        check_val("t6_err_clear", b_wr_err, 0.0);
        b_ldac = 1'b1;
        step();
        b_ldac = 1'b0;
        step(); step();
        check_val("t6_v1_settling", b_vout[1], 0.0);
        step();
        check_val("t6_v0", b_vout[0], 0.0);
        check_val("t6_v1", b_vout[1], 0.6);
        check_val("t6_v2", b_vout[2], 0.0);
        check_val("t6_code", real'(b_dac_code), real'(24'd60 << 8));
        b_vref = 5.0;
        step(); step(); step();
        check_val("t6_vref_hold", b_vout[1], 0.6);
        b_ldac = 1'b1;
        step();
        b_ldac = 1'b0;
        step(); step(); step();
        check_val("t6_v1_newref", b_vout[1], 5.0 * 60.0 / 255.0);
        check_val("t6_v2_newref", b_vout[2], 0.0);

        check_val("sb_empty", real'(due_q.size()), 0.0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
